clock_div_bank: RTL and testbench
=================================

// Module: clock_div_bank
// PURPOSE
//  NCH independent programmable clock dividers sharing one input clock.
//  Successor to the single-channel divider, adding per-channel enable, runtime
//  ratio reprogramming that avoids glitches, and a one-cycle tick strobe per channel.
//  Feeds the pipeline CPU's display-scan, UART-baud and single-step clocks.
// PARAMETERS
//  NCH        4   number of divider channels (1..16)
//  W          32  width of the ratio and counter fields
//  DEF_RATIO  1   ratio loaded into every channel at reset (must be nonzero)
//  CHW        derived = (NCH>1) ? $clog2(NCH) : 1; not user-set
// PORTS
//  clock      in   1        system clock; all logic on posedge
//  reset      in   1        reset, synchronous, active-high
//  en         in   NCH      per-channel run enable
//  cfg_we     in   1        ratio write strobe, one cycle
//  cfg_ch     in   CHW      target channel of the write
//  cfg_ratio  in   W        new divide ratio
//  clk_div    out  NCH      divided clock per channel, period 2*ratio clocks
//  tick       out  NCH      one-cycle pulse at each half-period boundary
//  cfg_pend   out  NCH      1 = written ratio is not yet applied
// BEHAVIOUR
//  Reset: count=0, active ratio=DEF_RATIO, pend=0, clk_div=0, tick=0.
//  Per channel, each cycle with en=1 and ratio!=0:
//   - count==ratio-1 ("wrap"): count<=0, clk_div toggles, tick<=1.
//   - otherwise: count<=count+1, tick<=0.
//   - Latency: tick and clk_div change register-to-output, with no combinational path.
//  en=0: count and clk_div hold, tick=0, and a pending ratio stays pending.
//  ratio==0 means halted: count stays 0, clk_div is forced 0, tick=0.
//  Reprogramming:
//   - cfg_we with cfg_ch<NCH stores cfg_ratio in pending[ch] and sets pend=1.
//   - cfg_ch>=NCH: the write is dropped and no state changes.
//   - Pending applies at the next wrap: active<=pending, pend<=0, count<=0.
//   - If the channel is halted (active==0), the write applies on the next
//     enabled cycle. count<=0, clk_div stays 0.
//   - A write in the same cycle as a wrap applies at that wrap, so the next
//     period already uses the new ratio. pend is not set.
//   - Multiple writes before a wrap: the last one wins.
//   - Writing 0 halts the channel at the next wrap. clk_div goes 0 in that
//     cycle instead of toggling, and there is no tick.
//  Arithmetic: the compare uses ratio-1 evaluated in W bits. Ratio 1 toggles
//   every cycle (period 2). Ratio 2^W-1 is legal. Counter width is W with no overflow.
//  Reset mid-period: reset overrides everything and discards pending writes.
// CONFIGURATION
//  CLKDIV_SYNC_EN defined:
//   - Adds input port sync_all (1 bit, after cfg_ratio).
//   - sync_all=1: every channel gets count<=0, clk_div<=0, tick<=0.
//   - Any pending ratio is applied immediately and pend is cleared.
//   - Overrides en and wrap. Priority is reset > sync_all > cfg_we.
//   - A cfg_we in the same cycle applies its value as active directly.
//  CLKDIV_SYNC_EN undefined: the port is absent and channels only realign via reset.
// TESTING
//  1 Reset, en=4'hF, DEF_RATIO=1: all clk_div toggle every cycle and tick is stuck at 1.
//  2 ch0 ratio=3: clk_div[0] is high 3 cycles, low 3 cycles. Tick occurs at counts 2, 5, 8.
//  3 ch1 at ratio=5, write 2 at count=1: pend=1 until the wrap at count 4.
//    Then the 4-cycle period starts. No short pulse occurs.
//  4 Write 7 to ch2 in its wrap cycle: the next half-period is 7 cycles
//    and pend stays 0.
//  5 en[3]=0 for 10 cycles mid-count: count and clk_div[3] freeze, then
//    resume the remaining count. Writing 0 to ch3 then halts it low.
//  6 CLKDIV_SYNC_EN: ch0=3 and ch1=4 mid-period, then pulse sync_all. Both
//    clk_div go low and tick together at cycle 12 after sync. cfg_ch=NCH is ignored.

Source files
------------

// File: rtl/clock_div_bank.sv
// Bank of NCH programmable clock dividers with per-channel enable, deferred ratio updates and tick strobes.
// Optional CLKDIV_SYNC_EN adds a sync_all input that realigns every channel at once.
module clock_div_bank #(
    parameter int          NCH       = 4,
    parameter int          W         = 32,
    parameter int unsigned DEF_RATIO = 1,
    localparam int         CHW       = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [NCH-1:0]   en,
    input  logic             cfg_we,
    input  logic [CHW-1:0]   cfg_ch,
    input  logic [W-1:0]     cfg_ratio,
`ifdef CLKDIV_SYNC_EN
    input  logic             sync_all,
`endif
    output logic [NCH-1:0]   clk_div,
    output logic [NCH-1:0]   tick,
    output logic [NCH-1:0]   cfg_pend
);

    logic sync;
`ifdef CLKDIV_SYNC_EN
    assign sync = sync_all;
`else
    assign sync = 1'b0;
`endif

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
            logic [W-1:0] count_reg;
            logic [W-1:0] active_reg;
            logic [W-1:0] pending_reg;
            logic         pend_reg;
            logic         clk_reg;
            logic         tick_reg;
            logic         wr;
            logic         wrap;
            logic [W-1:0] applied;

            // Out-of-range cfg_ch never matches any channel index, so such writes vanish.
            assign wr      = cfg_we && (cfg_ch == CHW'(gi));
            assign wrap    = (active_reg != '0) && (count_reg == active_reg - W'(1));
            // Ratio that takes effect at an update point; a same-cycle write beats an older pending one.
            assign applied = wr ? cfg_ratio : (pend_reg ? pending_reg : active_reg);

            always_ff @(posedge clock) begin
                if (reset) begin
                    count_reg   <= '0;
                    active_reg  <= W'(DEF_RATIO);
                    pending_reg <= '0;
                    pend_reg    <= 1'b0;
                    clk_reg     <= 1'b0;
                    tick_reg    <= 1'b0;
                end else if (sync) begin
                    count_reg  <= '0;
                    active_reg <= applied;
                    pend_reg   <= 1'b0;
                    clk_reg    <= 1'b0;
                    tick_reg   <= 1'b0;
                end else if (!en[gi]) begin
                    tick_reg <= 1'b0;
                    if (wr) begin
                        pending_reg <= cfg_ratio;
                        pend_reg    <= 1'b1;
                    end
                end else if (active_reg == '0) begin
                    // Halted channel: any enabled cycle is an update point.
                    count_reg  <= '0;
                    active_reg <= applied;
                    pend_reg   <= 1'b0;
                    clk_reg    <= 1'b0;
                    tick_reg   <= 1'b0;
                end else if (wrap) begin
                    count_reg  <= '0;
                    active_reg <= applied;
                    pend_reg   <= 1'b0;
                    if (applied == '0) begin
                        clk_reg  <= 1'b0;
                        tick_reg <= 1'b0;
                    end else begin
                        clk_reg  <= ~clk_reg;
                        tick_reg <= 1'b1;
                    end
                end else begin
                    count_reg <= count_reg + W'(1);
                    tick_reg  <= 1'b0;
                    if (wr) begin
                        pending_reg <= cfg_ratio;
                        pend_reg    <= 1'b1;
                    end
                end
            end

            assign clk_div[gi]  = clk_reg;
            assign tick[gi]     = tick_reg;
            assign cfg_pend[gi] = pend_reg;
        end
    endgenerate

endmodule

// File: tb/tb_clock_div_bank.sv
// Scoreboard bench for clock_div_bank: stimulus queues hand-computed expectations, a negedge monitor checks them.
// A second 3-channel instance exercises writes to a nonexistent channel.
module tb_clock_div_bank;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  en = '0;
    logic        cfg_we = 1'b0;
    logic [1:0]  cfg_ch = '0;
    logic [31:0] cfg_ratio = '0;
    logic        sync_all = 1'b0;
    logic [3:0]  clk_div, tick, cfg_pend;

    logic [2:0]  en3 = '0;
    logic        we3 = 1'b0;
    logic [1:0]  ch3 = '0;
    logic [31:0] ratio3 = '0;
    logic        sync3 = 1'b0;
    logic [2:0]  clk3, tick3, pend3;

    clock_div_bank #(.NCH(4), .W(32), .DEF_RATIO(1)) dut (
        .clock(clock), .reset(reset), .en(en), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
        .cfg_ratio(cfg_ratio),
`ifdef CLKDIV_SYNC_EN
        .sync_all(sync_all),
`endif
        .clk_div(clk_div), .tick(tick), .cfg_pend(cfg_pend)
    );

    clock_div_bank #(.NCH(3), .W(32), .DEF_RATIO(1)) dut3 (
        .clock(clock), .reset(reset), .en(en3), .cfg_we(we3), .cfg_ch(ch3),
        .cfg_ratio(ratio3),
`ifdef CLKDIV_SYNC_EN
        .sync_all(sync3),
`endif
        .clk_div(clk3), .tick(tick3), .cfg_pend(pend3)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int    cyc;
        int    kind;   // 0 clk_div, 1 tick, 2 cfg_pend, 3 dut3 clk_div, 4 dut3 cfg_pend
        int    ch;
        logic  val;
        string name;
    } exp_t;
    exp_t sb[$];
    int compared = 0;
    int mismatched = 0;

    function automatic logic actual(int kind, int ch);
        case (kind)
            0:       return clk_div[ch];
            1:       return tick[ch];
            2:       return cfg_pend[ch];
            3:       return clk3[ch];
            default: return pend3[ch];
        endcase
    endfunction

    task automatic push(int dt, int kind, int ch, logic v, string nm);
        exp_t e;
        e.cyc = cyc + dt; e.kind = kind; e.ch = ch; e.val = v; e.name = nm;
        sb.push_back(e);
    endtask

    // Monitor: compare every expectation that falls due on this cycle.
    always @(negedge clock) begin
        logic act;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc <= cyc) begin
                act = actual(sb[i].kind, sb[i].ch);
                compared++;
                if (sb[i].cyc < cyc || act !== sb[i].val) begin
                    mismatched++;
                    $display("FAIL %s ch%0d cyc%0d: got %b expected %b",
                             sb[i].name, sb[i].ch, sb[i].cyc, act, sb[i].val);
                end else begin
                    $display("ok   %s ch%0d cyc%0d: %b", sb[i].name, sb[i].ch, sb[i].cyc, act);
                end
                sb.delete(i);
            end
        end
    end

    task automatic step(int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic cfg(int ch, logic [31:0] r);
        cfg_we = 1'b1; cfg_ch = ch[1:0]; cfg_ratio = r;
    endtask

    task automatic reset_dut();
        reset = 1'b1; en = '0; cfg_we = 1'b0; en3 = '0; we3 = 1'b0; sync_all = 1'b0;
        step(1);
        reset = 1'b0;
        compared++;
        if (clk_div !== 4'b0000) begin
            mismatched++;
            $display("FAIL rst_direct clk_div cyc%0d: got %b expected 0000", cyc, clk_div);
        end else begin
            $display("ok   rst_direct clk_div cyc%0d: %b", cyc, clk_div);
        end
        compared++;
        if (tick !== 4'b0000) begin
            mismatched++;
            $display("FAIL rst_direct tick cyc%0d: got %b expected 0000", cyc, tick);
        end else begin
            $display("ok   rst_direct tick cyc%0d: %b", cyc, tick);
        end
        compared++;
        if (cfg_pend !== 4'b0000) begin
            mismatched++;
            $display("FAIL rst_direct cfg_pend cyc%0d: got %b expected 0000", cyc, cfg_pend);
        end else begin
            $display("ok   rst_direct cfg_pend cyc%0d: %b", cyc, cfg_pend);
        end
        for (int c = 0; c < 4; c++) begin
            push(0, 0, c, 1'b0, "rst_clk");
            push(0, 1, c, 1'b0, "rst_tick");
            push(0, 2, c, 1'b0, "rst_pend");
        end
    endtask

    initial begin
        step(2);

        // Default ratio 1: every channel toggles each cycle with tick held high.
        reset_dut();
        en = 4'hF;
        for (int k = 1; k <= 3; k++)
            for (int c = 0; c < 4; c++) begin
                push(k, 0, c, logic'(k % 2), "r1_clk");
                push(k, 1, c, 1'b1, "r1_tick");
            end
        step(4);

        // ch0 ratio 3 written on a wrap: 3 high, 3 low, ticks every 3 cycles.
        reset_dut();
        en = 4'b0001; cfg(0, 3);
        push(1, 2, 0, 1'b0, "r3_pend"); push(1, 0, 0, 1'b1, "r3_clk"); push(1, 1, 0, 1'b1, "r3_tick");
        push(2, 0, 0, 1'b1, "r3_clk");  push(2, 1, 0, 1'b0, "r3_tick");
        push(3, 0, 0, 1'b1, "r3_clk");  push(3, 1, 0, 1'b0, "r3_tick");
        push(4, 0, 0, 1'b0, "r3_clk");  push(4, 1, 0, 1'b1, "r3_tick");
        push(5, 1, 0, 1'b0, "r3_tick"); push(6, 0, 0, 1'b0, "r3_clk");
        push(7, 0, 0, 1'b1, "r3_clk");  push(7, 1, 0, 1'b1, "r3_tick");
        step(1); cfg_we = 1'b0;
        step(7);

        // ch1 ratio 5, rewrite to 2 mid-period: deferred to the wrap, no short pulse.
        reset_dut();
        en = 4'b0010; cfg(1, 5);
        push(3, 2, 1, 1'b1, "defer_pend"); push(5, 2, 1, 1'b1, "defer_pend");
        push(6, 2, 1, 1'b0, "defer_pend");
        push(5, 0, 1, 1'b1, "defer_clk");  push(6, 0, 1, 1'b0, "defer_clk");
        push(6, 1, 1, 1'b1, "defer_tick"); push(7, 0, 1, 1'b0, "defer_clk");
        push(7, 1, 1, 1'b0, "defer_tick"); push(8, 0, 1, 1'b1, "defer_clk");
        push(8, 1, 1, 1'b1, "defer_tick"); push(9, 0, 1, 1'b1, "defer_clk");
        push(10, 0, 1, 1'b0, "defer_clk");
        step(1); cfg_we = 1'b0;
        step(1); cfg(1, 2);
        step(1); cfg_we = 1'b0;
        step(8);

        // Pending write while disabled, then reset must discard it.
        reset_dut();
        cfg(0, 9);
        push(1, 2, 0, 1'b1, "dis_pend");
        step(1); cfg_we = 1'b0;
        reset_dut();

        // Write 7 to ch2 in its wrap cycle: applies immediately, pend never set.
        en = 4'b0100; cfg(2, 7);
        push(1, 2, 2, 1'b0, "wrapw_pend"); push(1, 0, 2, 1'b1, "wrapw_clk");
        push(1, 1, 2, 1'b1, "wrapw_tick"); push(7, 0, 2, 1'b1, "wrapw_clk");
        push(7, 1, 2, 1'b0, "wrapw_tick"); push(8, 0, 2, 1'b0, "wrapw_clk");
        push(8, 1, 2, 1'b1, "wrapw_tick");
        step(1); cfg_we = 1'b0;
        step(8);

        // ch3 ratio 4 frozen for 10 cycles, then a pending 0 halts it low at the wrap.
        reset_dut();
        en = 4'b1000; cfg(3, 4);
        push(4, 0, 3, 1'b1, "frz_clk");   push(4, 1, 3, 1'b0, "frz_tick");
        push(5, 0, 3, 1'b1, "frz_clk");   push(7, 2, 3, 1'b1, "frz_pend");
        push(12, 0, 3, 1'b1, "frz_clk");  push(12, 1, 3, 1'b0, "frz_tick");
        push(12, 2, 3, 1'b1, "frz_pend"); push(14, 0, 3, 1'b1, "frz_clk");
        push(15, 0, 3, 1'b0, "halt_clk"); push(15, 1, 3, 1'b0, "halt_tick");
        push(15, 2, 3, 1'b0, "halt_pend"); push(19, 0, 3, 1'b0, "halt_clk");
        push(19, 1, 3, 1'b0, "halt_tick");
        step(1); cfg_we = 1'b0;
        step(1); en = 4'b0000;
        step(4); cfg(3, 0);
        step(1); cfg_we = 1'b0;
        step(5); en = 4'b1000;
        step(8);

        // Write to channel 3 of a 3-channel bank is dropped.
        reset_dut();
        en3 = 3'b111; we3 = 1'b1; ch3 = 2'd3; ratio3 = 32'd9;
        for (int c = 0; c < 3; c++) begin
            push(1, 4, c, 1'b0, "drop_pend");
            push(2, 4, c, 1'b0, "drop_pend");
        end
        push(1, 3, 0, 1'b1, "drop_clk"); push(2, 3, 0, 1'b0, "drop_clk");
        push(3, 3, 0, 1'b1, "drop_clk");
        step(1); we3 = 1'b0;
        step(3);

`ifdef CLKDIV_SYNC_EN
        // ch0=3, ch1=4, then sync_all: both restart low and tick together 12 cycles later.
        reset_dut();
        en = 4'b0011; cfg(0, 3);
        push(3, 0, 0, 1'b0, "sync_clk");   push(3, 0, 1, 1'b0, "sync_clk");
        push(3, 1, 0, 1'b0, "sync_tick");  push(3, 1, 1, 1'b0, "sync_tick");
        push(6, 1, 0, 1'b1, "sync_tick");  push(7, 1, 1, 1'b1, "sync_tick");
        push(7, 1, 0, 1'b0, "sync_tick");
        push(15, 1, 0, 1'b1, "sync_tick"); push(15, 1, 1, 1'b1, "sync_tick");
        push(15, 0, 0, 1'b0, "sync_clk");  push(15, 0, 1, 1'b1, "sync_clk");
        step(1); cfg(1, 4);
        step(1); cfg_we = 1'b0; sync_all = 1'b1;
        step(1); sync_all = 1'b0;
        step(13);
`endif

        step(2);
        foreach (sb[i]) begin
            compared++;
            mismatched++;
            $display("FAIL %s ch%0d cyc%0d: never checked, expected %b", sb[i].name, sb[i].ch, sb[i].cyc, sb[i].val);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
